// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a req/gnt/rvalid data bus.
// A per-byte-lane sub-module builds the store byte enables and the
// replicated write data. The top module holds the access FSM, the
// timeout counter, load extraction/extension and exception reporting.

module mem_access_lane #(
  parameter int LANE   = 0,
  parameter int DATA_W = 32,
  parameter int IW     = 2
) (
  input  logic [1:0]        i_size,
  input  logic [IW-1:0]     i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_be,
  output logic [7:0]        o_wbyte
);
  logic [3:0]        w_bytes;
  int                w_src;
  logic [DATA_W-1:0] w_sh;

  // Lane enable window and the source byte of the replicated store data
  always_comb begin
    w_bytes = 4'd1 << i_size;
    o_be    = (LANE >= int'(i_idx)) && (LANE < int'(i_idx) + int'(w_bytes));
    w_src   = LANE & (int'(w_bytes) - 1);
    w_sh    = i_wdata >> (8 * w_src);
    o_wbyte = w_sh[7:0];
  end
endmodule

module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                acc_valid,
  input  logic                acc_we,
  input  logic [1:0]          acc_size,
  input  logic                acc_unsigned,
  input  logic [ADDR_W-1:0]   acc_addr,
  input  logic [DATA_W-1:0]   acc_wdata,
  input  logic                flush,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic [ADDR_W-1:0]   badvaddr,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(NB);
  localparam int CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic                r_we, r_uns;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic                r_exc_valid;
  logic [4:0]          r_exc_code;
  logic [ADDR_W-1:0]   r_badvaddr;

  logic                w_misal, w_tmo, w_accept, w_set_exc, w_cnt_clr, w_rd_ld;
  logic [4:0]          w_exc_code;
  logic [IW-1:0]       w_idx, w_idx_al;
  logic [3:0]          w_bytes;
  logic [DATA_W-1:0]   w_sh, w_mask, w_ext;
  logic                w_sgn;
  logic [NB-1:0]       w_be;
  logic [NB-1:0][7:0]  w_wlanes;

  assign w_idx = r_addr[IW-1:0];
  assign w_tmo = (r_cnt >= CW'(TIMEOUT - 1));

  // Alignment check on the incoming request; dword is illegal on a 32-bit bus
  always_comb begin
    w_misal = 1'b0;
    case (acc_size)
      2'd0:    w_misal = 1'b0;
      2'd1:    w_misal = acc_addr[0];
      2'd2:    w_misal = |acc_addr[1:0];
      default: w_misal = (DATA_W == 32) ? 1'b1 : |acc_addr[2:0];
    endcase
  end

  // Next state and per-cycle control; flush beats timeout, gnt/rvalid beat flush
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_set_exc  = 1'b0;
    w_exc_code = 5'd0;
    w_cnt_clr  = 1'b0;
    w_rd_ld    = 1'b0;
    case (r_state)
      S_IDLE: if (acc_valid && !flush) begin
        w_accept = 1'b1;
        if (w_misal) begin
          w_set_exc  = 1'b1;
          w_exc_code = acc_we ? 5'd5 : 5'd4;
        end else begin
          w_next    = S_REQ;
          w_cnt_clr = 1'b1;
        end
      end
      S_REQ: if (bus_gnt) begin
        w_cnt_clr = 1'b1;
        if (r_we) w_next = flush ? S_IDLE : S_RESP;
        else      w_next = flush ? S_DRAIN : S_WAIT;
      end else if (flush) begin
        w_next = S_IDLE;
      end else if (w_tmo) begin
        w_next     = S_IDLE;
        w_set_exc  = 1'b1;
        w_exc_code = 5'd7;
      end
      S_WAIT: if (bus_rvalid) begin
        w_next  = flush ? S_IDLE : S_RESP;
        w_rd_ld = !flush;
      end else if (flush) begin
        w_next = S_DRAIN;
      end else if (w_tmo) begin
        w_next     = S_IDLE;
        w_set_exc  = 1'b1;
        w_exc_code = 5'd7;
      end
      S_RESP:  w_next = S_IDLE;
      S_DRAIN: if (bus_rvalid || w_tmo) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pick the addressed slot from the read beat and extend it to DATA_W
  always_comb begin
    w_bytes  = 4'd1 << r_size;
    w_idx_al = w_idx & ~IW'(w_bytes - 4'd1);
    w_sh     = bus_rdata >> {w_idx_al, 3'b000};
    w_mask   = '0;
    for (int i = 0; i < DATA_W; i++) w_mask[i] = (i < 8 * int'(w_bytes));
    w_sgn    = |(w_sh & w_mask & ~(w_mask >> 1));
    w_ext    = (w_sh & w_mask) | ((!r_uns && w_sgn) ? ~w_mask : '0);
  end

  // State, counter, latched access and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= 5'd0;
      r_badvaddr  <= '0;
    end else begin
      r_state     <= w_next;
      r_exc_valid <= w_set_exc;
      if (w_cnt_clr)                                  r_cnt <= '0;
      else if (r_state != S_IDLE && r_state != S_RESP) r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_we    <= acc_we;
        r_uns   <= acc_unsigned;
        r_size  <= acc_size;
        r_addr  <= acc_addr;
        r_wdata <= acc_wdata;
      end
      if (w_rd_ld) r_rdata <= w_ext;
      if (w_set_exc) begin
        r_exc_code <= w_exc_code;
        r_badvaddr <= (r_state == S_IDLE) ? acc_addr : r_addr;
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    mem_access_lane #(.LANE(g), .DATA_W(DATA_W), .IW(IW)) u_lane (
      .i_size  (r_size),
      .i_idx   (w_idx),
      .i_wdata (r_wdata),
      .o_be    (w_be[g]),
      .o_wbyte (w_wlanes[g])
    );
  end

  assign stall     = (r_state != S_IDLE) | (acc_valid & ~flush);
  assign done      = (r_state == S_RESP) & ~flush;
  assign rdata     = r_rdata;
  assign exc_valid = r_exc_valid;
  assign exc_code  = r_exc_code;
  assign badvaddr  = r_badvaddr;
  assign bus_req   = (r_state == S_REQ);
  assign bus_we    = bus_req & r_we;
  assign bus_addr  = bus_req ? {r_addr[ADDR_W-1:IW], {IW{1'b0}}} : '0;
  assign bus_be    = bus_req ? w_be : '0;
  assign bus_wdata = bus_req ? w_wlanes : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: a 32-bit instance with a short timeout and a 64-bit instance.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance, TIMEOUT=4
  logic a_valid = 0, a_we = 0, a_uns = 0, a_flush = 0, a_gnt = 0, a_rvalid = 0;
  logic [1:0] a_size = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, a_brdata = 0;
  logic a_stall, a_done, a_exc, a_req, a_bwe;
  logic [31:0] a_rdata, a_bad, a_baddr, a_bwdata;
  logic [4:0] a_code;
  logic [3:0] a_be;

  // 64-bit instance, default timeout
  logic b_valid = 0, b_we = 0, b_uns = 0, b_flush = 0, b_gnt = 0, b_rvalid = 0;
  logic [1:0] b_size = 0;
  logic [31:0] b_addr = 0;
  logic [63:0] b_wdata = 0, b_brdata = 0;
  logic b_stall, b_done, b_exc, b_req, b_bwe;
  logic [63:0] b_rdata, b_bwdata;
  logic [31:0] b_bad, b_baddr;
  logic [4:0] b_code;
  logic [7:0] b_be;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .acc_valid(a_valid), .acc_we(a_we), .acc_size(a_size),
    .acc_unsigned(a_uns), .acc_addr(a_addr), .acc_wdata(a_wdata), .flush(a_flush),
    .stall(a_stall), .done(a_done), .rdata(a_rdata), .exc_valid(a_exc), .exc_code(a_code),
    .badvaddr(a_bad), .bus_req(a_req), .bus_we(a_bwe), .bus_addr(a_baddr), .bus_be(a_be),
    .bus_wdata(a_bwdata), .bus_gnt(a_gnt), .bus_rvalid(a_rvalid), .bus_rdata(a_brdata));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .acc_valid(b_valid), .acc_we(b_we), .acc_size(b_size),
    .acc_unsigned(b_uns), .acc_addr(b_addr), .acc_wdata(b_wdata), .flush(b_flush),
    .stall(b_stall), .done(b_done), .rdata(b_rdata), .exc_valid(b_exc), .exc_code(b_code),
    .badvaddr(b_bad), .bus_req(b_req), .bus_we(b_bwe), .bus_addr(b_baddr), .bus_be(b_be),
    .bus_wdata(b_bwdata), .bus_gnt(b_gnt), .bus_rvalid(b_rvalid), .bus_rdata(b_brdata));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start a new cycle: inputs change just after the rising edge
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Load on the 32-bit unit with gnt/rvalid at first opportunity; done at cycle 3
  task automatic ld_a(input string tag, input logic uns, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] bd, input logic [31:0] exp);
    cyc(); a_valid = 1; a_we = 0; a_size = sz; a_uns = uns; a_addr = addr;
    a_gnt = 1; a_rvalid = 1; a_brdata = bd;
    smp(); chk({tag, " c0 stall"}, 64'(a_stall), 64'd1); chk({tag, " c0 req"}, 64'(a_req), 64'd0);
    cyc(); a_valid = 0;
    smp(); chk({tag, " c1 req"}, 64'(a_req), 64'd1);
    chk({tag, " c1 addr"}, 64'(a_baddr), 64'(addr & 32'hFFFF_FFFC));
    cyc(); smp(); chk({tag, " c2 done"}, 64'(a_done), 64'd0);
    cyc(); smp(); chk({tag, " c3 done"}, 64'(a_done), 64'd1); chk({tag, " rdata"}, 64'(a_rdata), 64'(exp));
    chk({tag, " c3 exc"}, 64'(a_exc), 64'd0);
    cyc(); a_gnt = 0; a_rvalid = 0;
    smp(); chk({tag, " c4 done"}, 64'(a_done), 64'd0); chk({tag, " c4 stall"}, 64'(a_stall), 64'd0);
  endtask

  task automatic ld_b(input string tag, input logic uns, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [63:0] bd, input logic [63:0] exp);
    cyc(); b_valid = 1; b_we = 0; b_size = sz; b_uns = uns; b_addr = addr;
    b_gnt = 1; b_rvalid = 1; b_brdata = bd;
    cyc(); b_valid = 0;
    smp(); chk({tag, " addr"}, 64'(b_baddr), 64'(addr & 32'hFFFF_FFF8));
    cyc(); cyc(); smp(); chk({tag, " done"}, 64'(b_done), 64'd1); chk({tag, " rdata"}, b_rdata, exp);
    cyc(); b_gnt = 0; b_rvalid = 0;
  endtask

  // Misaligned request: no bus activity, exception the next cycle
  task automatic mis_a(input string tag, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [4:0] code);
    cyc(); a_valid = 1; a_we = we; a_size = sz; a_uns = 0; a_addr = addr; a_gnt = 1;
    cyc(); a_valid = 0;
    smp(); chk({tag, " req"}, 64'(a_req), 64'd0); chk({tag, " exc"}, 64'(a_exc), 64'd1);
    chk({tag, " code"}, 64'(a_code), 64'(code)); chk({tag, " bad"}, 64'(a_bad), 64'(addr));
    chk({tag, " done"}, 64'(a_done), 64'd0);
    cyc(); a_gnt = 0;
    smp(); chk({tag, " exc off"}, 64'(a_exc), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(); cyc(); smp();
    chk("rst stall", 64'(a_stall), 64'd0); chk("rst req", 64'(a_req), 64'd0);
    chk("rst rdata", 64'(a_rdata), 64'd0); chk("rst exc", 64'(a_exc), 64'd0);
    chk("rst b req", 64'(b_req), 64'd0);
    cyc(); reset_n = 1;

    // Byte loads, signed and unsigned
    ld_a("lb", 1'b0, 2'd0, 32'h1003, 32'h80FF_1234, 32'hFFFF_FF80);
    ld_a("lbu", 1'b1, 2'd0, 32'h1003, 32'h80FF_1234, 32'h0000_0080);
    ld_a("lh", 1'b0, 2'd1, 32'h1002, 32'h80FF_1234, 32'hFFFF_80FF);
    ld_a("lw", 1'b0, 2'd2, 32'h1004, 32'h80FF_1234, 32'h80FF_1234);

    // Halfword store: enables, replicated data, done two cycles after accept
    cyc(); a_valid = 1; a_we = 1; a_size = 2'd1; a_addr = 32'h2002; a_wdata = 32'h0000_ABCD; a_gnt = 1;
    cyc(); a_valid = 0;
    smp(); chk("sh req", 64'(a_req), 64'd1); chk("sh we", 64'(a_bwe), 64'd1);
    chk("sh be", 64'(a_be), 64'hC); chk("sh wdata", 64'(a_bwdata), 64'hABCD_ABCD);
    chk("sh addr", 64'(a_baddr), 64'h2000);
    cyc(); smp(); chk("sh done", 64'(a_done), 64'd1); chk("sh req off", 64'(a_req), 64'd0);
    cyc(); a_gnt = 0; smp(); chk("sh done off", 64'(a_done), 64'd0);

    // Misaligned accesses
    mis_a("mis lw", 1'b0, 2'd2, 32'h0006, 5'd4);
    mis_a("mis sw", 1'b1, 2'd2, 32'h0001, 5'd5);
    mis_a("mis d32", 1'b0, 2'd3, 32'h0000, 5'd4);

    // Flush in IDLE blocks acceptance
    cyc(); a_valid = 1; a_flush = 1; a_we = 0; a_size = 2'd2; a_addr = 32'h0300;
    smp(); chk("fl idle stall", 64'(a_stall), 64'd0);
    cyc(); a_valid = 0; a_flush = 0;
    smp(); chk("fl idle req", 64'(a_req), 64'd0);

    // Bus timeout: gnt never comes
    cyc(); a_valid = 1; a_we = 0; a_size = 2'd2; a_addr = 32'h0100; a_gnt = 0;
    cyc(); a_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) cyc();
      smp(); chk($sformatf("tmo req c%0d", c), 64'(a_req), 64'd1);
    end
    cyc(); smp();
    chk("tmo req off", 64'(a_req), 64'd0); chk("tmo exc", 64'(a_exc), 64'd1);
    chk("tmo code", 64'(a_code), 64'd7); chk("tmo bad", 64'(a_bad), 64'h100);
    chk("tmo done", 64'(a_done), 64'd0);
    cyc(); smp(); chk("tmo stall", 64'(a_stall), 64'd0);

    // Flush in WAIT, drain, then a new request waits until the drain ends
    cyc(); a_valid = 1; a_we = 0; a_size = 2'd2; a_addr = 32'h0040; a_gnt = 1; a_rvalid = 0;
    cyc(); a_valid = 0;                                  // cycle 1: REQ, granted
    cyc(); a_gnt = 0; a_flush = 1;                       // cycle 2: WAIT, flushed
    smp(); chk("dr c2 stall", 64'(a_stall), 64'd1);
    cyc(); a_flush = 0; a_valid = 1; a_addr = 32'h0080;  // cycle 3: DRAIN
    smp(); chk("dr c3 done", 64'(a_done), 64'd0); chk("dr c3 req", 64'(a_req), 64'd0);
    cyc(); smp(); chk("dr c4 req", 64'(a_req), 64'd0); chk("dr c4 exc", 64'(a_exc), 64'd0);
    cyc(); a_rvalid = 1;                                 // cycle 5: rvalid drained
    smp(); chk("dr c5 done", 64'(a_done), 64'd0); chk("dr c5 req", 64'(a_req), 64'd0);
    cyc(); a_rvalid = 0;                                 // cycle 6: IDLE, accepts
    smp(); chk("dr c6 done", 64'(a_done), 64'd0); chk("dr c6 exc", 64'(a_exc), 64'd0);
    chk("dr c6 req", 64'(a_req), 64'd0);
    cyc(); a_valid = 0; a_gnt = 1;                       // cycle 7: REQ for new load
    smp(); chk("dr c7 req", 64'(a_req), 64'd1); chk("dr c7 addr", 64'(a_baddr), 64'h80);

    // Reset during WAIT clears everything; a late rvalid is ignored
    cyc(); a_gnt = 0; reset_n = 0;                       // cycle 8: WAIT
    cyc(); a_rvalid = 1;
    smp(); chk("rw req", 64'(a_req), 64'd0); chk("rw stall", 64'(a_stall), 64'd0);
    chk("rw rdata", 64'(a_rdata), 64'd0); chk("rw bad", 64'(a_bad), 64'd0);
    chk("rw done", 64'(a_done), 64'd0); chk("rw be", 64'(a_be), 64'd0);
    cyc(); reset_n = 1;
    cyc(); smp(); chk("rw late done", 64'(a_done), 64'd0);
    a_rvalid = 0;

    // 64-bit word loads from the upper half
    ld_b("lwu64", 1'b1, 2'd2, 32'h000C, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    ld_b("lw64", 1'b0, 2'd2, 32'h000C, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    ld_b("ld64", 1'b1, 2'd3, 32'h0010, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);

    // 64-bit byte store
    cyc(); b_valid = 1; b_we = 1; b_size = 2'd0; b_addr = 32'h0005; b_wdata = 64'h5A; b_gnt = 1;
    cyc(); b_valid = 0;
    smp(); chk("sb64 be", 64'(b_be), 64'h20); chk("sb64 wdata", b_bwdata, 64'h5A5A_5A5A_5A5A_5A5A);
    chk("sb64 addr", 64'(b_baddr), 64'h0);
    cyc(); smp(); chk("sb64 done", 64'(b_done), 64'd1);
    cyc(); b_gnt = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
